// File: rtl/prf_freelist.sv
`default_nettype none

`ifndef WAYS
`define WAYS 3
`endif
`ifndef PRF
`define PRF 64
`endif

// ============================================================================
// Module   : prf_freelist
// Purpose  : Physical-register free bitmaps for the rename stage. Holds a
//            speculative bitmap that feeds the free-register selector and an
//            architectural bitmap updated only at retire. A squash rebuilds
//            the speculative copy from the architectural one in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module prf_freelist #(
    parameter  int WAYS = `WAYS,
    parameter  int PRF  = `PRF,
    parameter  int ARF  = 32,
    localparam int TW   = $clog2(PRF),
    localparam int CW   = $clog2(PRF + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WAYS-1:0]      alloc_valid,
    input  logic [WAYS*TW-1:0]   alloc_tag,
    input  logic [WAYS-1:0]      retire_valid,
    input  logic [WAYS*TW-1:0]   retire_new_tag,
    input  logic [WAYS*TW-1:0]   retire_old_tag,
    input  logic                 squash,
    output logic [PRF-1:0]       free_vec,
    output logic [CW-1:0]        free_count,
    output logic                 low,
    output logic                 error
);

    // Tags below ARF carry the initial architectural mapping, so only the
    // upper part of the register file starts out free.
    localparam logic [PRF-1:0] c_init_free  = {PRF{1'b1}} << ARF;
    localparam logic [CW-1:0]  c_init_count = CW'(PRF - ARF);
    localparam logic           c_init_low   = ((PRF - ARF) < WAYS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PRF-1:0] r_spec_free;
    logic [PRF-1:0] r_arch_free;
    logic [CW-1:0]  r_free_count;
    logic           r_low;
    logic           r_error;

    // ------------------------------------------------------------------
    // Per-slot tag views
    // ------------------------------------------------------------------
    logic [TW-1:0] w_alloc_tag   [WAYS];
    logic [TW-1:0] w_ret_new_tag [WAYS];
    logic [TW-1:0] w_ret_old_tag [WAYS];

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_unpack
            assign w_alloc_tag[g]   = alloc_tag[g*TW +: TW];
            assign w_ret_new_tag[g] = retire_new_tag[g*TW +: TW];
            assign w_ret_old_tag[g] = retire_old_tag[g*TW +: TW];
        end
    endgenerate

    // One-hot of a tag; a tag beyond PRF-1 shifts out and yields zero.
    function automatic logic [PRF-1:0] onehot(input logic [TW-1:0] tag);
        onehot = {{(PRF-1){1'b0}}, 1'b1} << tag;
    endfunction

    // ------------------------------------------------------------------
    // Masks
    // ------------------------------------------------------------------
    logic [PRF-1:0] w_alloc_mask;
    logic [PRF-1:0] w_ret_old_mask;
    logic [PRF-1:0] w_ret_new_mask;

    // OR together the one-hots of every valid slot; tag 0 is never released.
    always_comb begin
        w_alloc_mask   = '0;
        w_ret_old_mask = '0;
        w_ret_new_mask = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (alloc_valid[i]) begin
                w_alloc_mask = w_alloc_mask | onehot(w_alloc_tag[i]);
            end
            if (retire_valid[i]) begin
                w_ret_old_mask = w_ret_old_mask | onehot(w_ret_old_tag[i]);
                w_ret_new_mask = w_ret_new_mask | onehot(w_ret_new_tag[i]);
            end
        end
        w_ret_old_mask[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    logic w_err_alloc_busy;
    logic w_err_ret_free;
    logic w_err_alloc_dup;
    logic w_err_ret_dup;
    logic w_err_any;

    // Flag allocs of busy tags and releases of tags already free in arch state.
    always_comb begin
        w_err_alloc_busy = 1'b0;
        w_err_ret_free   = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (alloc_valid[i] && ((r_spec_free & onehot(w_alloc_tag[i])) == '0)) begin
                w_err_alloc_busy = 1'b1;
            end
            if (retire_valid[i] && (w_ret_old_tag[i] != '0) &&
                ((r_arch_free & onehot(w_ret_old_tag[i])) != '0)) begin
                w_err_ret_free = 1'b1;
            end
        end
    end

    // Flag the same tag appearing in two valid slots of one group. Old tag 0
    // is the permanent sink, so repeats of it are not a double release.
    always_comb begin
        w_err_alloc_dup = 1'b0;
        w_err_ret_dup   = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            for (int j = i + 1; j < WAYS; j++) begin
                if (alloc_valid[i] && alloc_valid[j] &&
                    (w_alloc_tag[i] == w_alloc_tag[j])) begin
                    w_err_alloc_dup = 1'b1;
                end
                if (retire_valid[i] && retire_valid[j] &&
                    (w_ret_old_tag[i] != '0) &&
                    (w_ret_old_tag[i] == w_ret_old_tag[j])) begin
                    w_err_ret_dup = 1'b1;
                end
            end
        end
    end

    assign w_err_any = w_err_alloc_busy | w_err_ret_free |
                       w_err_alloc_dup  | w_err_ret_dup;

    // ------------------------------------------------------------------
    // Next-state bitmaps
    // ------------------------------------------------------------------
    logic [PRF-1:0] w_arch_next;
    logic [PRF-1:0] w_spec_next;
    logic [CW-1:0]  w_count_next;
    logic           w_low_next;

    // Releases are applied after clears so a tag both taken and released in
    // one cycle ends up free. A squash reloads from the post-retire arch map
    // and drops this cycle's allocations.
    always_comb begin
        w_arch_next = (r_arch_free & ~w_ret_new_mask) | w_ret_old_mask;
        if (squash) begin
            w_spec_next = w_arch_next;
        end else begin
            w_spec_next = (r_spec_free & ~w_alloc_mask) | w_ret_old_mask;
        end
    end

    // Population count of the next speculative map, registered alongside it.
    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < PRF; i++) begin
            w_count_next = w_count_next + CW'(w_spec_next[i]);
        end
    end

    assign w_low_next = (w_count_next < CW'(WAYS));

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // All state updates on the clock; reset restores the initial mapping at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_spec_free  <= c_init_free;
            r_arch_free  <= c_init_free;
            r_free_count <= c_init_count;
            r_low        <= c_init_low;
            r_error      <= 1'b0;
        end else begin
            r_spec_free  <= w_spec_next;
            r_arch_free  <= w_arch_next;
            r_free_count <= w_count_next;
            r_low        <= w_low_next;
            r_error      <= r_error | w_err_any;
        end
    end

    assign free_vec   = r_spec_free;
    assign free_count = r_free_count;
    assign low        = r_low;
    assign error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_prf_freelist.sv
`default_nettype none

// ============================================================================
// Module   : tb_prf_freelist
// Purpose  : Self-checking bench for prf_freelist. Directed scenarios plus
//            randomized traffic compared against an array-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prf_freelist;

    localparam int WAYS = 3;
    localparam int PRF  = 64;
    localparam int ARF  = 32;
    localparam int TW   = 6;
    localparam int CW   = 7;

    logic               clock = 1'b0;
    logic               reset;
    logic [WAYS-1:0]    alloc_valid;
    logic [WAYS*TW-1:0] alloc_tag;
    logic [WAYS-1:0]    retire_valid;
    logic [WAYS*TW-1:0] retire_new_tag;
    logic [WAYS*TW-1:0] retire_old_tag;
    logic               squash;
    logic [PRF-1:0]     free_vec;
    logic [CW-1:0]      free_count;
    logic               low;
    logic               error;

    prf_freelist #(.WAYS(WAYS), .PRF(PRF), .ARF(ARF)) dut (
        .clock          (clock),
        .reset          (reset),
        .alloc_valid    (alloc_valid),
        .alloc_tag      (alloc_tag),
        .retire_valid   (retire_valid),
        .retire_new_tag (retire_new_tag),
        .retire_old_tag (retire_old_tag),
        .squash         (squash),
        .free_vec       (free_vec),
        .free_count     (free_count),
        .low            (low),
        .error          (error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus slots
    bit av [WAYS];
    int at [WAYS];
    bit rv [WAYS];
    int rn [WAYS];
    int ro [WAYS];
    bit sq;

    // Reference model: one flag per physical register
    bit m_spec [PRF];
    bit m_arch [PRF];
    bit m_err;

    task automatic chk_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int t = 0; t < PRF; t++) c += int'(m_spec[t]);
        return c;
    endfunction

    function automatic logic [PRF-1:0] m_vec();
        logic [PRF-1:0] v;
        for (int t = 0; t < PRF; t++) v[t] = m_spec[t];
        return v;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < PRF; t++) begin
            m_spec[t] = (t >= ARF);
            m_arch[t] = (t >= ARF);
        end
        m_err = 1'b0;
    endtask

    // Apply one cycle of the free-list rules to the model.
    task automatic model_step();
        bit narch [PRF];
        bit nspec [PRF];
        for (int i = 0; i < WAYS; i++) begin
            if (av[i] && !m_spec[at[i]]) m_err = 1'b1;
            if (rv[i] && ro[i] != 0 && m_arch[ro[i]]) m_err = 1'b1;
            for (int j = 0; j < WAYS; j++) begin
                if (i != j && av[i] && av[j] && at[i] == at[j]) m_err = 1'b1;
                if (i != j && rv[i] && rv[j] && ro[i] != 0 && ro[i] == ro[j]) m_err = 1'b1;
            end
        end
        narch = m_arch;
        for (int i = 0; i < WAYS; i++) if (rv[i]) narch[rn[i]] = 1'b0;
        for (int i = 0; i < WAYS; i++) if (rv[i] && ro[i] != 0) narch[ro[i]] = 1'b1;
        if (sq) begin
            nspec = narch;
        end else begin
            nspec = m_spec;
            for (int i = 0; i < WAYS; i++) if (av[i]) nspec[at[i]] = 1'b0;
            for (int i = 0; i < WAYS; i++) if (rv[i] && ro[i] != 0) nspec[ro[i]] = 1'b1;
        end
        m_arch = narch;
        m_spec = nspec;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < WAYS; i++) begin
            av[i] = 0; at[i] = 0; rv[i] = 0; rn[i] = 0; ro[i] = 0;
        end
        sq = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < WAYS; i++) begin
            alloc_valid[i]               = av[i];
            alloc_tag[i*TW +: TW]        = TW'(at[i]);
            retire_valid[i]              = rv[i];
            retire_new_tag[i*TW +: TW]   = TW'(rn[i]);
            retire_old_tag[i*TW +: TW]   = TW'(ro[i]);
        end
        squash = sq;
    endtask

    task automatic compare_all(input string where);
        chk_value({where, ".free_vec"},   free_vec,   m_vec());
        chk_value({where, ".free_count"}, free_count, m_count());
        chk_value({where, ".low"},        low,        (m_count() < WAYS));
        chk_value({where, ".error"},      error,      m_err);
    endtask

    // Drive current slots, clock once, advance model, compare.
    task automatic cycle(input string where);
        drive();
        @(posedge clock);
        #1;
        model_step();
        compare_all(where);
    endtask

    // Assert reset away from the clock edge and check it acts immediately.
    task automatic async_reset(input string where);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all(where);
        clear_stim();
        drive();
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Allocate up to n of the lowest free tags.
    task automatic alloc_lowest(input int n);
        int k = 0;
        clear_stim();
        for (int t = 0; t < PRF; t++) begin
            if (m_spec[t] && k < n) begin
                av[k] = 1; at[k] = t; k++;
            end
        end
    endtask

    task automatic rand_stim();
        int q[$];
        int busy[$];
        int p;
        clear_stim();
        sq = ($urandom_range(15) == 0);
        q = {};
        busy = {};
        for (int t = 0; t < PRF; t++) begin
            if (m_spec[t]) q.push_back(t); else busy.push_back(t);
        end
        for (int i = 0; i < WAYS; i++) begin
            if ($urandom_range(1) == 1 && q.size() > 0) begin
                p = $urandom_range(q.size() - 1);
                av[i] = 1; at[i] = q[p]; q.delete(p);
            end
        end
        q = {};
        for (int t = 0; t < PRF; t++) if (!m_arch[t]) q.push_back(t);
        for (int i = 0; i < WAYS; i++) begin
            if ($urandom_range(1) == 1 && q.size() > 0) begin
                p = $urandom_range(q.size() - 1);
                rv[i] = 1; ro[i] = q[p]; q.delete(p);
                rn[i] = busy[$urandom_range(busy.size() - 1)];
            end
        end
        if ($urandom_range(39) == 0) begin
            case ($urandom_range(3))
                0: begin
                    av[0] = 1; at[0] = busy[$urandom_range(busy.size() - 1)];
                end
                1: begin
                    q = {};
                    for (int t = 1; t < PRF; t++) if (m_arch[t]) q.push_back(t);
                    if (q.size() > 0) begin
                        rv[0] = 1; ro[0] = q[$urandom_range(q.size() - 1)];
                        rn[0] = $urandom_range(PRF - 1);
                    end
                end
                2: begin
                    if (!av[0]) at[0] = $urandom_range(PRF - 1);
                    av[0] = 1; av[1] = 1; at[1] = at[0];
                end
                default: begin
                    if (!rv[0] || ro[0] == 0) ro[0] = $urandom_range(PRF - 1, 1);
                    rv[0] = 1; rv[1] = 1; ro[1] = ro[0];
                    rn[0] = $urandom_range(PRF - 1); rn[1] = $urandom_range(PRF - 1);
                end
            endcase
        end
    endtask

    // Hard stop if something stalls the run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int err_age;
        clear_stim();
        reset = 1'b1;
        drive();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk_value("rst.free_vec",   free_vec,   64'hFFFF_FFFF_0000_0000);
        chk_value("rst.free_count", free_count, 32);
        chk_value("rst.low",        low,        1'b0);
        chk_value("rst.error",      error,      1'b0);
        @(negedge clock);
        reset = 1'b1;

        // Allocate 32..34
        clear_stim();
        av[0] = 1; at[0] = 32; av[1] = 1; at[1] = 33; av[2] = 1; at[2] = 34;
        cycle("alloc3");
        chk_value("alloc3.bits", free_vec[34:32], 3'b000);
        chk_value("alloc3.count", free_count, 29);

        // Retire old {5,6,0}, new {32,33,34}
        clear_stim();
        rv[0] = 1; ro[0] = 5; rn[0] = 32;
        rv[1] = 1; ro[1] = 6; rn[1] = 33;
        rv[2] = 1; ro[2] = 0; rn[2] = 34;
        cycle("retire");
        chk_value("retire.bits56", free_vec[6:5], 2'b11);
        chk_value("retire.bit0",   free_vec[0],   1'b0);
        chk_value("retire.count",  free_count,    31);

        // Allocate 35..40, then squash
        clear_stim();
        av[0] = 1; at[0] = 35; av[1] = 1; at[1] = 36; av[2] = 1; at[2] = 37;
        cycle("alloc35");
        clear_stim();
        av[0] = 1; at[0] = 38; av[1] = 1; at[1] = 39; av[2] = 1; at[2] = 40;
        cycle("alloc38");
        clear_stim();
        sq = 1;
        cycle("squash");
        chk_value("squash.bits", free_vec[40:35], 6'h3F);
        chk_value("squash.count", free_count, 31);

        // Back-to-back squash carrying a retire of old tag 7
        clear_stim();
        sq = 1; rv[0] = 1; ro[0] = 7; rn[0] = 41;
        av[1] = 1; at[1] = 50;
        cycle("squash_ret");
        chk_value("squash_ret.bit7",  free_vec[7],  1'b1);
        chk_value("squash_ret.bit50", free_vec[50], 1'b1);

        // Drain to two free tags
        for (int k = 0; k < 20 && m_count() > 2; k++) begin
            alloc_lowest((m_count() - 2 > WAYS) ? WAYS : m_count() - 2);
            cycle("drain");
        end
        chk_value("drain.count", free_count, 2);
        chk_value("drain.low",   low,        1'b1);

        // Alloc of busy tag 3
        clear_stim();
        av[0] = 1; at[0] = 3;
        cycle("err_alloc");
        chk_value("err_alloc.error", error, 1'b1);
        clear_stim();
        cycle("err_sticky");
        chk_value("err_sticky.error", error, 1'b1);

        // Reset while allocations are being presented
        alloc_lowest(WAYS);
        drive();
        async_reset("midreset");
        chk_value("midreset.free_vec", free_vec, 64'hFFFF_FFFF_0000_0000);
        chk_value("midreset.error",    error,    1'b0);

        // Release of already-free tag 50
        clear_stim();
        rv[0] = 1; ro[0] = 50; rn[0] = 32;
        cycle("err_free");
        chk_value("err_free.error", error, 1'b1);
        async_reset("reset2");

        // Same tag allocated and released in one cycle: free wins
        clear_stim();
        av[0] = 1; at[0] = 45;
        rv[0] = 1; ro[0] = 45; rn[0] = 33;
        cycle("alloc_ret_same");
        chk_value("alloc_ret_same.bit45", free_vec[45], 1'b1);
        async_reset("reset3");

        // Randomized traffic
        err_age = 0;
        for (int n = 0; n < 2000; n++) begin
            rand_stim();
            cycle("rand");
            if (m_err) err_age++;
            if (err_age > 2) begin
                clear_stim();
                rand_stim();
                drive();
                async_reset("rand_reset");
                err_age = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prf_freelist.md
# prf_freelist

Owner of the physical-register free state for the rename stage. Keeps two bitmaps: a speculative bitmap that drives the free-register selector, and an architectural bitmap updated only at retire. Dispatch clears speculative bits for tags it consumes, and retire returns superseded tags. On a branch squash, the speculative bitmap is rebuilt from the architectural one.

## Interface
Parameters:
- `WAYS`, default `` `WAYS ``: allocations and retires per cycle.
- `PRF`, default `` `PRF ``: number of physical registers. Tag width is `TW = $clog2(PRF)`.
- `ARF`, default 32: number of architectural registers. Tags 0..ARF-1 hold the initial mapping at reset.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `alloc_valid`  in  WAYS  dispatch consumed `alloc_tag[i]` this cycle.
- `alloc_tag`  in  WAYS×TW  tags taken by dispatch, sourced from the selector result.
- `retire_valid`  in  WAYS  retire slot i commits this cycle.
- `retire_new_tag`  in  WAYS×TW  tag that becomes architectural.
- `retire_old_tag`  in  WAYS×TW  superseded tag, returned to free.
- `squash`  in  1  mispredict recovery request.
- `free_vec`  out  PRF  registered speculative free bitmap, 1 = free; this is the selector request input.
- `free_count`  out  $clog2(PRF+1)  registered popcount of `free_vec`.
- `low`  out  1  registered; high when `free_count < WAYS`, so dispatch must stall.
- `error`  out  1  sticky protocol-violation flag.

## Operation
- State: `spec_free[PRF]`, `arch_free[PRF]`, `free_count`, `low`, `error`.
- Reset state, applied asynchronously while `reset` = 0:
  - `spec_free` = `arch_free` = 1 for tags ≥ ARF, 0 for tags < ARF.
  - `free_count` = PRF−ARF.
  - `low` = (PRF−ARF < WAYS).
  - `error` = 0.
- Masks, built from valid slots only:
  - `A`: OR of one-hots of `alloc_tag`.
  - `R`: OR of one-hots of `retire_old_tag`.
  - `N`: OR of one-hots of `retire_new_tag`.
  - Tag 0 is never freed: bit 0 of `R` is forced to 0.
- `arch_next` = (`arch_free` & ~`N`) | `R`.
- `spec_next`:
  - `squash` = 0: (`spec_free` & ~`A`) | `R`.
  - `squash` = 1: `arch_next`. Same-cycle retires are included, and `alloc_valid` is ignored.
- When the same tag appears in both `A` and `R` in one cycle, the set (free) wins.
- `free_count` and `low` are computed from `spec_next` and registered together with it.
- `error` is set, and stays set until reset, on any of:
  - a valid alloc of a tag whose `spec_free` bit = 0;
  - a valid retire whose `retire_old_tag` (≠ 0) already has `arch_free` = 1;
  - duplicate tags among valid alloc slots;
  - duplicate tags among valid retire-old slots.
- When `error` fires, state still updates per the equations above.

## Timing
- All outputs are registered. An effect appears one cycle after the inputs that cause it.
- An alloc in cycle t clears `free_vec` at t+1. The selector must not re-grant a tag in cycle t. Dispatch handles this by stalling or by using the same-cycle grant only.
- A retire in cycle t makes the tag visible in `free_vec` at t+1.
- `squash` in cycle t gives a fully restored `free_vec`, `free_count` and `low` at t+1. There is no multi-cycle recovery.
- Back-to-back squashes are legal; each one reloads from `arch_next`.
- If `reset` is asserted mid-operation, state returns to reset values immediately. Inputs are ignored until `reset` deasserts.

## Test plan
Configuration for all scenarios: PRF=64, WAYS=3, ARF=32.
- **Reset:** deassert `reset` → `free_vec` = 0xFFFF_FFFF_0000_0000, `free_count` = 32, `low` = 0, `error` = 0.
- **Allocate:** alloc tags 32, 33, 34 in one cycle → next cycle bits 32–34 = 0, `free_count` = 29. Repeat allocs until 2 tags remain → `low` = 1.
- **Retire:** retire old = {5, 6, 0}, new = {32, 33, 34} → next cycle `free_vec` bits 5 and 6 = 1, bit 0 stays 0, `free_count` rises by 2.
- **Squash:** allocate 35–40, retire nothing, then assert `squash` → next cycle bits 35–40 = 1 again, `free_count` matches the architectural bitmap. A squash in the same cycle as a retire of old tag 7 → bit 7 = 1.
- **Errors:** alloc of tag 3 (not free) → `error` = 1 next cycle and stays 1. Free of an already-free tag 50 → `error` = 1. Same tag in both an alloc slot and a retire-old slot in one cycle → bit = 1.
- **Mid-operation reset:** assert `reset` while allocs are active → outputs return to reset values in the same cycle, with no wait for a clock edge.
